// File: rtl/memory_access_pkg.sv
// memory_access_pkg: shared types for the memory access unit.
// Size encodings, FSM state encoding, word-index shift, alignment helper.
package memory_access_pkg;

    typedef enum logic [1:0] {
        SIZE_BYTE    = 2'b00,
        SIZE_HALF    = 2'b01,
        SIZE_WORD    = 2'b10,
        SIZE_ILLEGAL = 2'b11
    } size_e;

    typedef enum logic [2:0] {
        IDLE       = 3'd0,
        ISSUE_READ = 3'd1,
        WAIT_READ  = 3'd2,
        WRITE      = 3'd3,
        RESPOND    = 3'd4
    } state_e;

    // Byte address to word index shift.
    localparam int WORD_SHIFT = 2;

    function automatic logic is_misaligned(size_e size, logic [1:0] offset);
        logic bad;
        bad = 1'b1;
        case (size)
            SIZE_BYTE: bad = 1'b0;
            SIZE_HALF: bad = offset[0];
            SIZE_WORD: bad = |offset;
            default:   bad = 1'b1;
        endcase
        return bad;
    endfunction

endpackage

// File: rtl/memory_access_if.sv
// memory_access_if: core-side request/response bundle.
// master = core (drives request), slave = memory_access_unit.
interface memory_access_if #(
    parameter int ADDRESS_WIDTH = 32,
    parameter int DATA_WIDTH    = 32
);
    logic                     request_valid;
    logic                     request_ready;
    logic                     request_write;
    logic [1:0]               request_size;
    logic                     request_unsigned;
    logic [ADDRESS_WIDTH-1:0] request_address;
    logic [DATA_WIDTH-1:0]    request_write_data;
    logic                     response_valid;
    logic [DATA_WIDTH-1:0]    response_read_data;
    logic                     misaligned_error;

    modport master (
        output request_valid, request_write, request_size,
        output request_unsigned, request_address, request_write_data,
        input  request_ready, response_valid, response_read_data,
        input  misaligned_error
    );

    modport slave (
        input  request_valid, request_write, request_size,
        input  request_unsigned, request_address, request_write_data,
        output request_ready, response_valid, response_read_data,
        output misaligned_error
    );
endinterface

// File: rtl/memory_lane_align.sv
// memory_lane_align: combinational sub-word load extract/extend and store merge.
// Ports: size_i, offset_i, unsigned_i, read_word_i, store_data_i -> load_data_o, merged_word_o.
module memory_lane_align
    import memory_access_pkg::*;
#(
    parameter int DATA_WIDTH = 32
) (
    input  size_e                 size_i,
    input  logic [1:0]            offset_i,
    input  logic                  unsigned_i,
    input  logic [DATA_WIDTH-1:0] read_word_i,
    input  logic [DATA_WIDTH-1:0] store_data_i,
    output logic [DATA_WIDTH-1:0] load_data_o,
    output logic [DATA_WIDTH-1:0] merged_word_o
);
    localparam logic [DATA_WIDTH-1:0] BYTE_MASK = DATA_WIDTH'(8'hFF);
    localparam logic [DATA_WIDTH-1:0] HALF_MASK = DATA_WIDTH'(16'hFFFF);

    logic [4:0]            byte_shift;
    logic [4:0]            half_shift;
    logic [DATA_WIDTH-1:0] byte_lane;
    logic [DATA_WIDTH-1:0] half_lane;
    logic                  byte_sign;
    logic                  half_sign;

    assign byte_shift = {offset_i, 3'b000};
    assign half_shift = {offset_i[1], 4'b0000};
    assign byte_lane  = read_word_i >> byte_shift;
    assign half_lane  = read_word_i >> half_shift;
    assign byte_sign  = byte_lane[7] & ~unsigned_i;
    assign half_sign  = half_lane[15] & ~unsigned_i;

    always_comb begin
        load_data_o   = read_word_i;
        merged_word_o = store_data_i;
        case (size_i)
            SIZE_BYTE: begin
                load_data_o   = {{(DATA_WIDTH-8){byte_sign}}, byte_lane[7:0]};
                merged_word_o = (read_word_i & ~(BYTE_MASK << byte_shift))
                              | ((store_data_i & BYTE_MASK) << byte_shift);
            end
            SIZE_HALF: begin
                load_data_o   = {{(DATA_WIDTH-16){half_sign}}, half_lane[15:0]};
                merged_word_o = (read_word_i & ~(HALF_MASK << half_shift))
                              | ((store_data_i & HALF_MASK) << half_shift);
            end
            default: begin
                load_data_o   = read_word_i;
                merged_word_o = store_data_i;
            end
        endcase
    end
endmodule

// File: rtl/memory_access_unit.sv
// memory_access_unit: byte-addressed load/store initiator for a word-only memory.
// Ports: clock, reset_n, core (request/response, slave), memory_* (word-indexed memory port).
module memory_access_unit
    import memory_access_pkg::*;
#(
    parameter int ADDRESS_WIDTH = 32,
    parameter int DATA_WIDTH    = 32
) (
    input  logic                     clock,
    input  logic                     reset_n,
    memory_access_if.slave           core,
    output logic                     memory_read_enable,
    output logic [ADDRESS_WIDTH-1:0] memory_read_address,
    input  logic [DATA_WIDTH-1:0]    memory_read_value,
    output logic                     memory_write_enable,
    output logic [ADDRESS_WIDTH-1:0] memory_write_address,
    output logic [DATA_WIDTH-1:0]    memory_write_value
);
    state_e                   state_q, state_d;
    logic                     write_q;
    size_e                    size_q;
    logic                     unsigned_q;
    logic [ADDRESS_WIDTH-1:0] address_q;
    logic [DATA_WIDTH-1:0]    write_data_q;

    logic                     mem_re_q;
    logic [ADDRESS_WIDTH-1:0] mem_raddr_q;
    logic                     mem_we_q;
    logic [ADDRESS_WIDTH-1:0] mem_waddr_q;
    logic [DATA_WIDTH-1:0]    mem_wval_q;
    logic                     resp_valid_q;
    logic                     resp_err_q;
    logic [DATA_WIDTH-1:0]    resp_data_q;

    size_e                    req_size;
    logic                     accept;
    logic                     req_misaligned;
    logic [DATA_WIDTH-1:0]    read_word;
    logic [DATA_WIDTH-1:0]    load_data;
    logic [DATA_WIDTH-1:0]    merged_word;

    assign req_size       = size_e'(core.request_size);
    assign accept         = core.request_valid && (state_q == IDLE);
    assign req_misaligned = is_misaligned(req_size, core.request_address[1:0]);

    // Memory floats its read port outside the registered-read cycle.
    assign read_word = (state_q == WAIT_READ) ? memory_read_value : '0;

    memory_lane_align #(.DATA_WIDTH(DATA_WIDTH)) u_align (
        .size_i       (size_q),
        .offset_i     (address_q[1:0]),
        .unsigned_i   (unsigned_q),
        .read_word_i  (read_word),
        .store_data_i (write_data_q),
        .load_data_o  (load_data),
        .merged_word_o(merged_word)
    );

    always_comb begin
        state_d = state_q;
        case (state_q)
            IDLE: begin
                if (core.request_valid) begin
                    if (req_misaligned)
                        state_d = RESPOND;
                    else if (core.request_write && req_size == SIZE_WORD)
                        state_d = WRITE;
                    else
                        state_d = ISSUE_READ;
                end
            end
            ISSUE_READ: state_d = WAIT_READ;
            WAIT_READ:  state_d = write_q ? WRITE : RESPOND;
            WRITE:      state_d = RESPOND;
            RESPOND:    state_d = IDLE;
            default:    state_d = IDLE;
        endcase
    end

    // Memory-side and response outputs are registered copies of the
    // next-state decode so they only ever change on a rising edge.
    always_ff @(posedge clock or negedge reset_n) begin
        if (!reset_n) begin
            state_q      <= IDLE;
            write_q      <= 1'b0;
            size_q       <= SIZE_BYTE;
            unsigned_q   <= 1'b0;
            address_q    <= '0;
            write_data_q <= '0;
            mem_re_q     <= 1'b0;
            mem_raddr_q  <= '0;
            mem_we_q     <= 1'b0;
            mem_waddr_q  <= '0;
            mem_wval_q   <= '0;
            resp_valid_q <= 1'b0;
            resp_err_q   <= 1'b0;
            resp_data_q  <= '0;
        end else begin
            state_q      <= state_d;
            mem_re_q     <= (state_d == ISSUE_READ);
            mem_we_q     <= (state_d == WRITE);
            resp_valid_q <= (state_d == RESPOND);
            resp_err_q   <= accept && req_misaligned;
            if (state_q == WAIT_READ && !write_q)
                resp_data_q <= load_data;
            else
                resp_data_q <= '0;
            if (accept) begin
                write_q      <= core.request_write;
                size_q       <= req_size;
                unsigned_q   <= core.request_unsigned;
                address_q    <= core.request_address;
                write_data_q <= core.request_write_data;
            end
            if (accept && state_d == ISSUE_READ)
                mem_raddr_q <= core.request_address >> WORD_SHIFT;
            if (accept && state_d == WRITE) begin
                mem_waddr_q <= core.request_address >> WORD_SHIFT;
                mem_wval_q  <= core.request_write_data;
            end else if (state_q == WAIT_READ && state_d == WRITE) begin
                mem_waddr_q <= address_q >> WORD_SHIFT;
                mem_wval_q  <= merged_word;
            end
        end
    end

    assign core.request_ready      = (state_q == IDLE);
    assign core.response_valid     = resp_valid_q;
    assign core.response_read_data = resp_data_q;
    assign core.misaligned_error   = resp_err_q;
    assign memory_read_enable      = mem_re_q;
    assign memory_read_address     = mem_raddr_q;
    assign memory_write_enable     = mem_we_q;
    assign memory_write_address    = mem_waddr_q;
    assign memory_write_value      = mem_wval_q;
endmodule
